// File: rtl/life_pkg.sv
// Shared types and constants for the serial Game-of-Life cell.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package life_pkg;

  // Cell sequencer states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SCAN   = 2'd1,
    ST_UPDATE = 2'd2
  } life_state_t;

  localparam int NUM_NEIGHBORS = 8;
  localparam int COUNT_W       = 4;
  localparam int SEL_W         = $clog2(NUM_NEIGHBORS);

  localparam logic [COUNT_W-1:0] BIRTH_COUNT   = COUNT_W'(3);
  localparam logic [COUNT_W-1:0] SURVIVE_COUNT = COUNT_W'(2);

  // Index of the final neighbour visited during a scan.
  localparam logic [SEL_W-1:0] LAST_SELECT = SEL_W'(NUM_NEIGHBORS - 1);

endpackage

// File: rtl/life_rule.sv
// Conway next-state rule: birth on exactly BIRTH_COUNT, survival on SURVIVE_COUNT.
// Latency: purely combinational.
// Backpressure: none.
// Ports: alive (current state), count (live neighbours), next_alive (rule result).
module life_rule
  import life_pkg::*;
(
  input  logic               alive,
  input  logic [COUNT_W-1:0] count,
  output logic               next_alive
);

  // A count of 3 always yields a live cell; a count of 2 only keeps one alive.
  assign next_alive = (count == BIRTH_COUNT) || (alive && (count == SURVIVE_COUNT));

endmodule

// File: rtl/serial_life_cell.sv
// Single Game-of-Life cell that scans its neighbours one per cycle via an external mux.
// Latency: step accepted at edge E -> alive and done update at edge E+9.
// Backpressure: step/load only honoured while idle (busy low); requests while busy are dropped.
// Ports:
//   clk, rst            clock, async active-high reset
//   step                start one generation (idle only)
//   load, load_value    overwrite the cell state (idle only, wins over step)
//   neighbor_in         external mux output for the neighbour addressed by select
//   select              registered neighbour index driven to the external mux
//   alive, count        registered cell state and live-neighbour total
//   busy, done          sequencer active flag and one-cycle completion pulse
module serial_life_cell
  import life_pkg::*;
#(
  parameter logic INIT_STATE = 1'b0
)(
  input  logic               clk,
  input  logic               rst,
  input  logic               step,
  input  logic               load,
  input  logic               load_value,
  input  logic               neighbor_in,
  output logic [SEL_W-1:0]   select,
  output logic               alive,
  output logic [COUNT_W-1:0] count,
  output logic               busy,
  output logic               done
);

  life_state_t state;
  logic        next_alive;

  life_rule u_rule (
    .alive      (alive),
    .count      (count),
    .next_alive (next_alive)
  );

  assign busy = (state != ST_IDLE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= ST_IDLE;
      select <= '0;
      count  <= '0;
      alive  <= INIT_STATE;
      done   <= 1'b0;
    end else begin
      // done is a pulse: only the UPDATE branch raises it for one cycle.
      done <= 1'b0;
      case (state)
        ST_IDLE: begin
          select <= '0;
          if (load) begin
            // Load outranks step; a coincident step is dropped.
            alive <= load_value;
          end else if (step) begin
            count <= '0;
            state <= ST_SCAN;
          end
        end

        ST_SCAN: begin
          // neighbor_in reflects the current select, so accumulate before advancing.
          count <= count + {{(COUNT_W-1){1'b0}}, neighbor_in};
          if (select == LAST_SELECT) begin
            select <= '0;
            state  <= ST_UPDATE;
          end else begin
            select <= select + SEL_W'(1);
          end
        end

        ST_UPDATE: begin
          alive <= next_alive;
          done  <= 1'b1;
          state <= ST_IDLE;
        end

        default: begin
          select <= '0;
          state  <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
